// File: rtl/spi_bus_arbiter.sv
// Round-robin arbiter sharing one byte-level SPI master between the SSD1306
// display (CS, DC) and the keyboard scanner (CS2, MISO readback).
module spi_bus_arbiter #(
  parameter int unsigned CS_SETUP_CLKS = 2,
  parameter int unsigned CS_HOLD_CLKS  = 2,
  parameter int unsigned MAX_BURST     = 64
) (
  input  logic       i_Clk,
  input  logic       i_Reset,
  input  logic       i_Disp_Req,
  input  logic [7:0] i_Disp_Byte,
  input  logic       i_Disp_DC,
  input  logic       i_Disp_Last,
  output logic       o_Disp_Grant,
  output logic       o_Disp_Ack,
  input  logic       i_Kbd_Req,
  input  logic [7:0] i_Kbd_Byte,
  input  logic       i_Kbd_Last,
  output logic       o_Kbd_Grant,
  output logic       o_Kbd_Ack,
  output logic       o_Kbd_RX_DV,
  output logic [7:0] o_Kbd_RX_Byte,
  output logic [7:0] o_TX_Byte,
  output logic       o_TX_DV,
  input  logic       i_TX_Ready,
  input  logic       i_RX_DV,
  input  logic [7:0] i_RX_Byte,
  output logic       o_CS,
  output logic       o_CS2,
  output logic       o_DC
);

  localparam int unsigned BW   = $clog2(MAX_BURST + 1);
  localparam int unsigned CMAX = (CS_SETUP_CLKS > CS_HOLD_CLKS) ? CS_SETUP_CLKS : CS_HOLD_CLKS;
  localparam int unsigned CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_SEND,
    S_WAIT,
    S_HOLD
  } state_t;

  state_t          state_q;
  logic            sel_kbd_q;
  logic            last_kbd_q;
  logic            last_q;
  logic [BW-1:0]   burst_q;
  logic [CW-1:0]   cnt_q;

  logic sel_req_c, other_req_c, pick_kbd_c;
  logic setup_done_c, hold_done_c, burst_full_c, issue_c;

  assign sel_req_c    = sel_kbd_q ? i_Kbd_Req : i_Disp_Req;
  assign other_req_c  = sel_kbd_q ? i_Disp_Req : i_Kbd_Req;
  // On a tie the requester that was not served last wins.
  assign pick_kbd_c   = i_Kbd_Req && (!i_Disp_Req || !last_kbd_q);
  assign setup_done_c = (cnt_q == CW'(CS_SETUP_CLKS - 1));
  assign hold_done_c  = (cnt_q == CW'(CS_HOLD_CLKS - 1));
  assign burst_full_c = (burst_q == BW'(MAX_BURST));
  // The last setup cycle doubles as the first send cycle so CS leads TX_DV by exactly CS_SETUP_CLKS.
  assign issue_c      = (state_q == S_SEND) || ((state_q == S_SETUP) && setup_done_c);

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      state_q       <= S_IDLE;
      sel_kbd_q     <= 1'b0;
      last_kbd_q    <= 1'b1;
      last_q        <= 1'b0;
      burst_q       <= '0;
      cnt_q         <= '0;
      o_Disp_Grant  <= 1'b0;
      o_Disp_Ack    <= 1'b0;
      o_Kbd_Grant   <= 1'b0;
      o_Kbd_Ack     <= 1'b0;
      o_Kbd_RX_DV   <= 1'b0;
      o_Kbd_RX_Byte <= 8'h00;
      o_TX_Byte     <= 8'h00;
      o_TX_DV       <= 1'b0;
      o_CS          <= 1'b1;
      o_CS2         <= 1'b1;
      o_DC          <= 1'b0;
    end else begin
      o_TX_DV     <= 1'b0;
      o_Disp_Ack  <= 1'b0;
      o_Kbd_Ack   <= 1'b0;
      o_Kbd_RX_DV <= 1'b0;

      case (state_q)
        S_IDLE: begin
          if (i_Disp_Req || i_Kbd_Req) begin
            sel_kbd_q    <= pick_kbd_c;
            o_Disp_Grant <= !pick_kbd_c;
            o_Kbd_Grant  <= pick_kbd_c;
            o_CS         <= pick_kbd_c;
            o_CS2        <= !pick_kbd_c;
            cnt_q        <= '0;
            burst_q      <= '0;
            state_q      <= S_SETUP;
          end
        end
        S_SETUP: begin
          if (!setup_done_c) cnt_q <= cnt_q + CW'(1);
        end
        S_WAIT: begin
          if (i_RX_DV) begin
            if (sel_kbd_q) begin
              o_Kbd_RX_Byte <= i_RX_Byte;
              o_Kbd_RX_DV   <= 1'b1;
            end
            if (last_q || (burst_full_c && other_req_c)) begin
              cnt_q   <= '0;
              state_q <= S_HOLD;
            end else begin
              state_q <= S_SEND;
            end
          end
        end
        S_HOLD: begin
          if (hold_done_c) begin
            o_CS         <= 1'b1;
            o_CS2        <= 1'b1;
            o_Disp_Grant <= 1'b0;
            o_Kbd_Grant  <= 1'b0;
            last_kbd_q   <= sel_kbd_q;
            burst_q      <= '0;
            state_q      <= S_IDLE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase

      // Byte issue, or release of an abandoned transaction.
      if (issue_c) begin
        if (!sel_req_c) begin
          cnt_q   <= '0;
          state_q <= S_HOLD;
        end else if (i_TX_Ready) begin
          o_TX_Byte  <= sel_kbd_q ? i_Kbd_Byte : i_Disp_Byte;
          if (!sel_kbd_q) o_DC <= i_Disp_DC;
          o_TX_DV    <= 1'b1;
          o_Disp_Ack <= !sel_kbd_q;
          o_Kbd_Ack  <= sel_kbd_q;
          last_q     <= sel_kbd_q ? i_Kbd_Last : i_Disp_Last;
          if (!burst_full_c) burst_q <= burst_q + BW'(1);
          state_q    <= S_WAIT;
        end else begin
          state_q <= S_SEND;
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Randomized bench for spi_bus_arbiter: requester/SPI-master models plus a
// transaction-level model of round-robin arbitration with burst capping.
module tb_spi_bus_arbiter;

  localparam int SETUP = 2;
  localparam int HOLD  = 2;
  localparam int MAXB  = 4;

  logic       clk = 1'b0;
  logic       i_Reset;
  logic       i_Disp_Req, i_Disp_DC, i_Disp_Last, o_Disp_Grant, o_Disp_Ack;
  logic [7:0] i_Disp_Byte;
  logic       i_Kbd_Req, i_Kbd_Last, o_Kbd_Grant, o_Kbd_Ack, o_Kbd_RX_DV;
  logic [7:0] i_Kbd_Byte, o_Kbd_RX_Byte, o_TX_Byte, i_RX_Byte;
  logic       o_TX_DV, i_TX_Ready, i_RX_DV, o_CS, o_CS2, o_DC;

  always #5 clk = ~clk;

  spi_bus_arbiter #(.CS_SETUP_CLKS(SETUP), .CS_HOLD_CLKS(HOLD), .MAX_BURST(MAXB)) dut (
    .i_Clk(clk), .i_Reset(i_Reset),
    .i_Disp_Req(i_Disp_Req), .i_Disp_Byte(i_Disp_Byte), .i_Disp_DC(i_Disp_DC),
    .i_Disp_Last(i_Disp_Last), .o_Disp_Grant(o_Disp_Grant), .o_Disp_Ack(o_Disp_Ack),
    .i_Kbd_Req(i_Kbd_Req), .i_Kbd_Byte(i_Kbd_Byte), .i_Kbd_Last(i_Kbd_Last),
    .o_Kbd_Grant(o_Kbd_Grant), .o_Kbd_Ack(o_Kbd_Ack), .o_Kbd_RX_DV(o_Kbd_RX_DV),
    .o_Kbd_RX_Byte(o_Kbd_RX_Byte), .o_TX_Byte(o_TX_Byte), .o_TX_DV(o_TX_DV),
    .i_TX_Ready(i_TX_Ready), .i_RX_DV(i_RX_DV), .i_RX_Byte(i_RX_Byte),
    .o_CS(o_CS), .o_CS2(o_CS2), .o_DC(o_DC)
  );

  // Stimulus owned by the test sequence.
  logic [7:0] dq[$];
  logic       dcq[$];
  logic [7:0] kq[$];
  bit         disp_go, kbd_go, disp_abandon, rdy_rand;
  int         stray_cnt;
  int         model_last_kbd;

  // State owned by the per-cycle driver/monitor loop.
  int         disp_idx, kbd_idx, lat, stray_done;
  bit         busy, in_frame, cur_kbd, seen_tx, hold_arm, outstanding, prev_both_high;
  logic       prev_dc;
  logic [7:0] rxb;
  int         cur_cnt, cur_setup, cur_hold;
  int         v_both, v_dc, v_grant, v_gap, v_tx, acks_d, acks_k;
  int         fo_own[$], fo_cnt[$], fo_setup[$], fo_hold[$];
  logic [8:0] od[$];
  logic [7:0] ok[$], orx[$];

  int n_chk, n_pass;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic monitor_step();
    bit cs_low;
    cs_low = !o_CS || !o_CS2;
    if (!o_CS && !o_CS2) v_both++;
    if (o_Disp_Grant !== !o_CS || o_Kbd_Grant !== !o_CS2) v_grant++;
    if (o_DC !== prev_dc && !(o_TX_DV && o_Disp_Ack)) v_dc++;
    if (o_TX_DV !== (o_Disp_Ack || o_Kbd_Ack)) v_tx++;
    if (o_Kbd_RX_DV) orx.push_back(o_Kbd_RX_Byte);
    if (o_Disp_Ack) acks_d++;
    if (o_Kbd_Ack) acks_k++;
    if (!in_frame && cs_low) begin
      if (!prev_both_high) v_gap++;
      in_frame = 1; cur_kbd = !o_CS2; cur_cnt = 0; cur_setup = 0; cur_hold = 0;
      seen_tx = 0; hold_arm = 0;
    end
    if (in_frame && cs_low) begin
      if (i_RX_DV) begin outstanding = 0; hold_arm = 1; cur_hold = 0; end
      if (hold_arm) cur_hold++;
      if (o_TX_DV) begin
        if (outstanding || (o_Kbd_Ack !== cur_kbd)) v_tx++;
        outstanding = 1; seen_tx = 1; hold_arm = 0; cur_cnt++;
        if (cur_kbd) ok.push_back(o_TX_Byte);
        else od.push_back({o_DC, o_TX_Byte});
      end else if (!seen_tx) begin
        cur_setup++;
      end
    end else if (in_frame) begin
      fo_own.push_back(int'(cur_kbd)); fo_cnt.push_back(cur_cnt);
      fo_setup.push_back(cur_setup); fo_hold.push_back(cur_hold);
      in_frame = 0;
    end
    prev_dc = o_DC;
    prev_both_high = o_CS && o_CS2;
  endtask

  task automatic drive_step();
    i_RX_DV = 1'b0;
    // SPI master: fixed-function MISO reply after a random transfer time.
    if (o_TX_DV) begin
      busy = 1; lat = $urandom_range(2, 5); rxb = o_TX_Byte ^ 8'h5A;
    end else if (busy) begin
      lat--;
      if (lat == 0) begin i_RX_DV = 1'b1; i_RX_Byte = rxb; busy = 0; end
    end else if (stray_done != stray_cnt) begin
      i_RX_DV = 1'b1; i_RX_Byte = 8'hC3; stray_done++;
    end
    i_TX_Ready = !busy && (!rdy_rand || $urandom_range(0, 3) != 0);
    if (!disp_go) disp_idx = 0; else if (o_Disp_Ack) disp_idx++;
    if (!kbd_go) kbd_idx = 0; else if (o_Kbd_Ack) kbd_idx++;
    if (disp_go && disp_idx < dq.size()) begin
      i_Disp_Req = 1; i_Disp_Byte = dq[disp_idx]; i_Disp_DC = dcq[disp_idx];
      i_Disp_Last = (disp_idx == dq.size() - 1) && !disp_abandon;
    end else begin
      i_Disp_Req = 0; i_Disp_Last = 0;
    end
    if (kbd_go && kbd_idx < kq.size()) begin
      i_Kbd_Req = 1; i_Kbd_Byte = kq[kbd_idx]; i_Kbd_Last = (kbd_idx == kq.size() - 1);
    end else begin
      i_Kbd_Req = 0; i_Kbd_Last = 0;
    end
  endtask

  initial begin
    i_Disp_Req = 0; i_Disp_Byte = 0; i_Disp_DC = 0; i_Disp_Last = 0;
    i_Kbd_Req = 0; i_Kbd_Byte = 0; i_Kbd_Last = 0;
    i_TX_Ready = 0; i_RX_DV = 0; i_RX_Byte = 0;
    disp_idx = 0; kbd_idx = 0; busy = 0; lat = 0; stray_done = 0;
    in_frame = 0; outstanding = 0; prev_both_high = 1; prev_dc = 0;
    forever begin
      @(negedge clk);
      if (i_Reset) begin
        busy = 0; in_frame = 0; outstanding = 0; prev_both_high = 1; prev_dc = 0;
        i_RX_DV = 0; i_TX_Ready = 0; i_Disp_Req = 0; i_Kbd_Req = 0;
        disp_idx = 0; kbd_idx = 0;
      end else begin
        monitor_step();
        drive_step();
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    disp_go = 0; kbd_go = 0; i_Reset = 1;
    repeat (2) @(negedge clk);
    i_Reset = 0; model_last_kbd = 1;
    repeat (2) @(negedge clk);
  endtask

  task automatic load_rand(input int nd, input int nk);
    dq.delete(); dcq.delete(); kq.delete();
    for (int i = 0; i < nd; i++) begin
      dq.push_back(8'($urandom)); dcq.push_back(1'($urandom));
    end
    for (int i = 0; i < nk; i++) kq.push_back(8'($urandom));
  endtask

  // Runs the loaded transactions and compares against the arbitration model.
  task automatic run_case(input string nm, input int kbd_at, input int exp_hold, input bit exact_setup);
    int f0, d0, k0, r0, ad0, ak0, vb0, vd0, vg0, vp0, vt0;
    int e_own[$], e_cnt[$];
    int rd, rk, lk, rem, oth, take, cyc;
    bit k;
    f0 = fo_own.size(); d0 = od.size(); k0 = ok.size(); r0 = orx.size();
    ad0 = acks_d; ak0 = acks_k;
    vb0 = v_both; vd0 = v_dc; vg0 = v_grant; vp0 = v_gap; vt0 = v_tx;
    rd = dq.size(); rk = kq.size(); lk = model_last_kbd;
    while (rd > 0 || rk > 0) begin
      k    = (rd > 0 && rk > 0) ? !lk[0] : (rk > 0);
      rem  = k ? rk : rd;
      oth  = k ? rd : rk;
      take = (oth > 0 && rem > MAXB) ? MAXB : rem;
      e_own.push_back(int'(k)); e_cnt.push_back(take);
      if (k) rk -= take; else rd -= take;
      lk = int'(k);
    end
    model_last_kbd = lk;

    disp_go = 1; kbd_go = (kbd_at == 0);
    cyc = 0;
    while (cyc < 4000) begin
      @(negedge clk);
      cyc++;
      if (!kbd_go && disp_idx >= kbd_at) kbd_go = 1;
      if (kbd_go && disp_idx == dq.size() && kbd_idx == kq.size() && !in_frame && o_CS && o_CS2) break;
    end
    check({nm, ".timeout"}, cyc < 4000, 1);
    repeat (3) @(negedge clk);
    disp_go = 0; kbd_go = 0;
    repeat (2) @(negedge clk);

    check({nm, ".frames"}, fo_own.size() - f0, e_own.size());
    for (int i = 0; i < e_own.size(); i++) begin
      if (f0 + i < fo_own.size()) begin
        check({nm, ".frame_own_len"}, fo_own[f0+i] * 256 + fo_cnt[f0+i], e_own[i] * 256 + e_cnt[i]);
        if (exact_setup) check({nm, ".setup"}, fo_setup[f0+i], SETUP);
        else check({nm, ".setup_min"}, fo_setup[f0+i] >= SETUP, 1);
        check({nm, ".hold"}, fo_hold[f0+i], exp_hold);
      end
    end
    check({nm, ".disp_count"}, od.size() - d0, dq.size());
    for (int i = 0; i < dq.size(); i++)
      if (d0 + i < od.size()) check({nm, ".disp_dc_byte"}, od[d0+i], {dcq[i], dq[i]});
    check({nm, ".kbd_count"}, ok.size() - k0, kq.size());
    check({nm, ".rx_count"}, orx.size() - r0, kq.size());
    for (int i = 0; i < kq.size(); i++) begin
      if (k0 + i < ok.size()) check({nm, ".kbd_byte"}, ok[k0+i], kq[i]);
      if (r0 + i < orx.size()) check({nm, ".kbd_rx"}, orx[r0+i], kq[i] ^ 8'h5A);
    end
    check({nm, ".acks"}, (acks_d - ad0) * 256 + (acks_k - ak0), dq.size() * 256 + kq.size());
    check({nm, ".both_cs_low"}, v_both - vb0, 0);
    check({nm, ".dc_glitch"}, v_dc - vd0, 0);
    check({nm, ".grant_vs_cs"}, v_grant - vg0, 0);
    check({nm, ".cs_gap"}, v_gap - vp0, 0);
    check({nm, ".txdv_protocol"}, v_tx - vt0, 0);
  endtask

  initial begin
    int cyc, nd, nk, rx0;
    n_chk = 0; n_pass = 0; stray_cnt = 0;
    disp_go = 0; kbd_go = 0; disp_abandon = 0; rdy_rand = 0; model_last_kbd = 1;
    i_Reset = 1;
    repeat (3) @(negedge clk);
    i_Reset = 0;
    repeat (2) @(negedge clk);

    check("rst.cs_cs2", {o_CS, o_CS2}, 2'b11);
    check("rst.grants_acks", {o_Disp_Grant, o_Kbd_Grant, o_Disp_Ack, o_Kbd_Ack}, 4'b0);
    check("rst.dvs", {o_TX_DV, o_Kbd_RX_DV}, 2'b0);
    check("rst.bytes_dc", {o_TX_Byte, o_Kbd_RX_Byte, o_DC}, 17'h0);

    // A stray RX_DV while idle must not produce anything.
    rx0 = orx.size();
    stray_cnt++;
    repeat (6) @(negedge clk);
    check("stray.rx_dv", orx.size() - rx0, 0);
    check("stray.frames", fo_own.size(), 0);

    // 1. Display-only command sequence.
    dq = '{8'hAE, 8'hD5, 8'h80}; dcq = '{1'b0, 1'b0, 1'b0}; kq.delete();
    run_case("t1", 0, HOLD, 1);

    // 2. Simultaneous single-byte requests after reset: display wins the first tie.
    do_reset();
    dq = '{8'h3C}; dcq = '{1'b1}; kq = '{8'h91};
    run_case("t2", 0, HOLD, 1);

    // 3. Keyboard readback; DC keeps its last display value.
    dq.delete(); dcq.delete(); kq = '{8'h00};
    run_case("t3", 0, HOLD, 1);
    check("t3.dc_kept", o_DC, 1'b1);
    check("t3.rx_byte", o_Kbd_RX_Byte, 8'h5A);

    // 4. Burst cap: keyboard requests during a 10-byte display stream.
    do_reset();
    load_rand(10, 1);
    run_case("t4", 2, HOLD, 1);

    // 5. Reset mid-transfer acts without a clock edge.
    do_reset();
    load_rand(3, 0);
    disp_go = 1;
    cyc = 0;
    while (cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (o_TX_DV) break;
    end
    check("t5.txdv_timeout", cyc < 200, 1);
    #1 i_Reset = 1;
    #1;
    check("t5.cs_async", o_CS, 1'b1);
    check("t5.txdv_async", o_TX_DV, 1'b0);
    check("t5.grant_async", o_Disp_Grant, 1'b0);
    disp_go = 0;
    repeat (2) @(negedge clk);
    i_Reset = 0; model_last_kbd = 1;
    repeat (2) @(negedge clk);
    load_rand(2, 1);
    run_case("t5.after", 0, HOLD, 1);

    // 6. Display abandons after one byte: one SEND cycle plus HOLD after the RX_DV.
    dq = '{8'h21}; dcq = '{1'b1}; kq.delete();
    disp_abandon = 1;
    run_case("t6", 0, 1 + HOLD, 1);
    disp_abandon = 0;

    // Random mixes with a stalling SPI master.
    rdy_rand = 1;
    for (int r = 0; r < 6; r++) begin
      nd = $urandom_range(0, 9);
      nk = $urandom_range(0, 6);
      if (nd == 0 && nk == 0) nd = 1;
      load_rand(nd, nk);
      run_case($sformatf("rnd%0d", r), 0, HOLD, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
